// File: rtl/sprite_row_shifter.sv
// Sprite row serialiser: buffers WORDS packed words, skips x_offset strobes,
// then emits one BPP-bit pixel per en strobe in normal or mirrored order.
`timescale 1ns/1ps
module sprite_row_shifter #(
  parameter int BPP   = 2,
  parameter int PPW   = 16,
  parameter int WORDS = 2,
  parameter int XW    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BPP*PPW-1:0]   wr_data,
  input  logic                 arm,
  input  logic [XW-1:0]        x_offset,
  input  logic                 mirror,
  input  logic                 en,
  output logic [BPP-1:0]       pix_out,
  output logic                 pix_active,
  output logic                 done
);

  localparam int WW  = BPP * PPW;
  localparam int N   = WORDS * PPW;
  localparam int WCW = $clog2(WORDS + 1);
  localparam int PCW = $clog2(N + 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_DELAY  = 2'd2;
  localparam logic [1:0] S_SHIFT  = 2'd3;

  logic [1:0]     state;
  logic [WCW-1:0] wcnt;
  logic [PCW-1:0] pcnt;
  logic [XW-1:0]  dcnt;
  logic           mir;
  logic [WW-1:0]  row_w [WORDS];
  logic [BPP-1:0] pix_sel;

  assign wr_ready = (state == S_FILL);

  // Pixel selection by index; the buffer is never shifted, so a mirrored row
  // simply counts the index down from the far end.
  always_comb begin
    int idx;
    pix_sel = '0;
    idx = mir ? (N - 1 - int'(pcnt)) : int'(pcnt);
    for (int w = 0; w < WORDS; w++) begin
      for (int k = 0; k < PPW; k++) begin
        if (idx == w * PPW + k) pix_sel = row_w[w][k*BPP +: BPP];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FILL;
      wcnt       <= '0;
      pcnt       <= '0;
      dcnt       <= '0;
      mir        <= 1'b0;
      pix_out    <= '0;
      pix_active <= 1'b0;
      done       <= 1'b0;
      for (int w = 0; w < WORDS; w++) row_w[w] <= '0;
    end else begin
      done <= 1'b0;
      if (en && state != S_SHIFT) begin
        pix_out    <= '0;
        pix_active <= 1'b0;
      end
      case (state)
        S_FILL: begin
          if (wr_valid) begin
            for (int w = 0; w < WORDS; w++) begin
              if (wcnt == WCW'(w)) row_w[w] <= wr_data;
            end
            wcnt <= wcnt + WCW'(1);
            if (wcnt == WCW'(WORDS - 1)) state <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (arm) begin
            dcnt  <= x_offset;
            mir   <= mirror;
            pcnt  <= '0;
            state <= (x_offset != '0) ? S_DELAY : S_SHIFT;
          end
        end
        S_DELAY: begin
          // The strobe that exhausts the offset emits nothing itself.
          if (en) begin
            if (dcnt != '0) dcnt <= dcnt - XW'(1);
            if (dcnt <= XW'(1)) state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            pix_out    <= pix_sel;
            pix_active <= 1'b1;
            pcnt       <= pcnt + PCW'(1);
            if (pcnt == PCW'(N - 1)) begin
              state <= S_FILL;
              wcnt  <= '0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_shifter.sv
// Scoreboard bench for sprite_row_shifter: a 2bpp/16ppw/2-word instance and a
// 4bpp/8ppw/3-word instance share stimulus, gated by sel.
`timescale 1ns/1ps
module tb_sprite_row_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_valid, arm, mirror, en, sel;
  logic [31:0] wr_data;
  logic [9:0]  x_offset;
  logic        rdy_a, act_a, done_a, rdy_b, act_b, done_b;
  logic [1:0]  pix_a;
  logic [3:0]  pix_b;

  sprite_row_shifter #(.BPP(2), .PPW(16), .WORDS(2), .XW(10)) dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid & ~sel), .wr_ready(rdy_a),
    .wr_data(wr_data), .arm(arm & ~sel), .x_offset(x_offset), .mirror(mirror),
    .en(en & ~sel), .pix_out(pix_a), .pix_active(act_a), .done(done_a));

  sprite_row_shifter #(.BPP(4), .PPW(8), .WORDS(3), .XW(10)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid & sel), .wr_ready(rdy_b),
    .wr_data(wr_data), .arm(arm & sel), .x_offset(x_offset), .mirror(mirror),
    .en(en & sel), .pix_out(pix_b), .pix_active(act_b), .done(done_b));

  logic [3:0] obs_pix;
  logic       obs_act, obs_done, obs_rdy;
  assign obs_pix  = sel ? pix_b : {2'b00, pix_a};
  assign obs_act  = sel ? act_b : act_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_rdy  = sel ? rdy_b : rdy_a;

  typedef struct {
    logic [3:0] pix;
    logic       act;
    logic       dn;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] words[3];
  int          cur_bpp, cur_ppw, cur_words, cur_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic use_dut(input bit b);
    sel       = b;
    cur_bpp   = b ? 4 : 2;
    cur_ppw   = b ? 8 : 16;
    cur_words = b ? 3 : 2;
    cur_n     = cur_words * cur_ppw;
  endtask

  function automatic logic [3:0] ref_pix(input int j, input logic m);
    int idx;
    logic [31:0] w;
    idx = m ? (cur_n - 1 - j) : j;
    w = words[idx / cur_ppw] >> (cur_bpp * (idx % cur_ppw));
    return w[3:0] & ((cur_bpp == 4) ? 4'hF : 4'h3);
  endfunction

  task automatic load_row();
    for (int w = 0; w < cur_words; w++) begin
      wr_valid = 1'b1;
      wr_data  = words[w];
      n_cmp++;
      if (obs_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL load_ready word%0d got %b need 1", w, obs_rdy);
      end
      tick();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    n_cmp++;
    if (obs_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL load_full got wr_ready=%b need 0", obs_rdy);
    end
  endtask

  // Arms the loaded row and strobes through offset, pixels and optional blank.
  task automatic run_row(input logic [9:0] off, input logic m, input int gap, input bit blank);
    exp_t e;
    int total;
    arm = 1'b1; x_offset = off; mirror = m;
    tick();
    arm = 1'b0; x_offset = 10'h3FF; mirror = ~m;
    total = int'(off) + cur_n + (blank ? 1 : 0);
    for (int s = 0; s < total; s++) begin
      if (s < int'(off) || s >= int'(off) + cur_n) begin
        e.pix = 4'h0; e.act = 1'b0;
      end else begin
        e.pix = ref_pix(s - int'(off), m); e.act = 1'b1;
      end
      e.dn = (s == int'(off) + cur_n - 1);
      sbq.push_back(e);
      en = 1'b1;
      tick();
      en = 1'b0;
      e = sbq.pop_front();
      n_cmp++;
      if (obs_pix !== e.pix || obs_act !== e.act || obs_done !== e.dn) begin
        n_bad++;
        $display("FAIL strobe%0d off=%0d mir=%b got pix=%0h act=%b done=%b need pix=%0h act=%b done=%b",
                 s, off, m, obs_pix, obs_act, obs_done, e.pix, e.act, e.dn);
      end
      for (int g = 1; g < gap; g++) begin
        tick();
        n_cmp++;
        if (obs_pix !== e.pix || obs_act !== e.act || obs_done !== 1'b0) begin
          n_bad++;
          $display("FAIL hold strobe%0d+%0d got pix=%0h act=%b done=%b need pix=%0h act=%b done=0",
                   s, g, obs_pix, obs_act, obs_done, e.pix, e.act);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int b = 0; b < 2; b++) begin
      use_dut(b[0]);
      n_cmp++;
      if (obs_pix !== 4'h0 || obs_act !== 1'b0 || obs_done !== 1'b0 || obs_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL reset dut%0d got pix=%0h act=%b done=%b rdy=%b need 0 0 0 1",
                 b, obs_pix, obs_act, obs_done, obs_rdy);
      end
    end
    use_dut(1'b0);
  endtask

  task automatic test_basic();
    use_dut(1'b0);
    words[0] = 32'h0000_0001; words[1] = 32'h8000_0000;
    load_row();
    run_row(10'd0, 1'b0, 1, 1'b1);
  endtask

  task automatic test_mirror();
    use_dut(1'b0);
    words[0] = 32'h0000_0001; words[1] = 32'h8000_0000;
    load_row();
    run_row(10'd0, 1'b1, 1, 1'b1);
  endtask

  task automatic test_offset();
    use_dut(1'b0);
    words[0] = $urandom; words[1] = $urandom;
    load_row();
    run_row(10'd5, 1'b0, 3, 1'b1);
  endtask

  task automatic test_handshake();
    logic [31:0] d[4];
    use_dut(1'b0);
    d[0] = 32'h1234_5678; d[1] = 32'h9ABC_DEF0; d[2] = 32'hFFFF_FFFF; d[3] = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1;
      wr_data  = d[c];
      n_cmp++;
      if (obs_rdy !== (c < 2)) begin
        n_bad++;
        $display("FAIL handshake cycle%0d got wr_ready=%b need %b", c, obs_rdy, (c < 2));
      end
      tick();
    end
    wr_valid = 1'b0;
    words[0] = d[0]; words[1] = d[1];
    run_row(10'd0, 1'b0, 1, 1'b1);
  endtask

  task automatic test_arm_in_fill();
    use_dut(1'b0);
    words[0] = $urandom; words[1] = $urandom;
    wr_valid = 1'b1; wr_data = words[0];
    tick();
    wr_valid = 1'b0; arm = 1'b1; x_offset = 10'd3;
    tick();
    arm = 1'b0;
    n_cmp++;
    if (obs_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL arm_in_fill got wr_ready=%b need 1", obs_rdy);
    end
    wr_valid = 1'b1; wr_data = words[1];
    tick();
    wr_valid = 1'b0;
    n_cmp++;
    if (obs_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL arm_in_fill_loaded got wr_ready=%b need 0", obs_rdy);
    end
    run_row(10'd2, 1'b1, 2, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    use_dut(1'b0);
    words[0] = $urandom; words[1] = $urandom;
    load_row();
    arm = 1'b1; x_offset = 10'd0; mirror = 1'b0;
    tick();
    arm = 1'b0;
    for (int p = 0; p < 9; p++) begin
      en = 1'b1;
      tick();
      en = 1'b0;
      n_cmp++;
      if (obs_pix !== ref_pix(p, 1'b0) || obs_act !== 1'b1) begin
        n_bad++;
        $display("FAIL pre_abort pixel%0d got pix=%0h act=%b need pix=%0h act=1",
                 p, obs_pix, obs_act, ref_pix(p, 1'b0));
      end
    end
    en = 1'b1; reset = 1'b1;
    tick();
    en = 1'b0; reset = 1'b0;
    n_cmp++;
    if (obs_pix !== 4'h0 || obs_act !== 1'b0 || obs_rdy !== 1'b1 || obs_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort got pix=%0h act=%b rdy=%b done=%b need 0 0 1 0",
               obs_pix, obs_act, obs_rdy, obs_done);
    end
    words[0] = $urandom; words[1] = $urandom;
    load_row();
    run_row(10'd1, 1'b1, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] last;
    use_dut(1'b0);
    words[0] = $urandom; words[1] = $urandom;
    load_row();
    run_row(10'd0, 1'b0, 1, 1'b0);
    last = ref_pix(cur_n - 1, 1'b0);
    words[0] = $urandom; words[1] = $urandom;
    load_row();
    n_cmp++;
    if (obs_pix !== last || obs_act !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold got pix=%0h act=%b need pix=%0h act=1", obs_pix, obs_act, last);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    n_cmp++;
    if (obs_pix !== 4'h0 || obs_act !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_blank got pix=%0h act=%b need 0 0", obs_pix, obs_act);
    end
    run_row(10'd4, 1'b1, 1, 1'b1);
  endtask

  task automatic test_wide();
    use_dut(1'b1);
    words[0] = 32'h7654_3210; words[1] = 32'hFEDC_BA98; words[2] = $urandom;
    load_row();
    run_row(10'd2, 1'b0, 1, 1'b1);
    words[0] = $urandom; words[1] = $urandom; words[2] = $urandom;
    load_row();
    run_row(10'd0, 1'b1, 2, 1'b1);
    use_dut(1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; arm = 1'b0;
    x_offset = '0; mirror = 1'b0; en = 1'b0;
    use_dut(1'b0);
    test_reset();
    test_basic();
    test_mirror();
    test_offset();
    test_handshake();
    test_arm_in_fill();
    test_reset_mid_shift();
    test_back_to_back();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_row_shifter.md
Name: sprite_row_shifter

Overview:
- Parametrised pixel serialiser for sprite rendering.
- Accepts a sprite row as WORDS packed memory words over a valid/ready write port.
- Waits a programmable number of pixel strobes (horizontal offset), then emits one BPP-bit pixel per strobe, optionally mirrored.
- Sits between the sprite memory fetch logic and the VGA pixel mux; generalises the fixed 16-pixel, 2-bit sprite shifter.

Parameters:
- BPP, 2, bits per pixel.
- PPW, 16, pixels per memory word; word width is BPP*PPW.
- WORDS, 2, words per sprite row; row length N = WORDS*PPW pixels.
- XW, 10, width of the horizontal offset counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  write word present
- wr_ready  out  1  shifter can accept a word
- wr_data  in  BPP*PPW  sprite word; pixel k occupies bits [k*BPP+BPP-1 : k*BPP]
- arm  in  1  start row output; samples x_offset and mirror
- x_offset  in  XW  en strobes to skip before the first pixel
- mirror  in  1  1 = emit row right-to-left
- en  in  1  pixel strobe; all output advance is gated by en
- pix_out  out  BPP  current pixel, registered; 0 = transparent
- pix_active  out  1  pix_out carries a sprite pixel
- done  out  1  one-cycle pulse after the last pixel is emitted

Behaviour:
- Reset, synchronous, priority over everything:
  - State = FILL, word count = 0, row buffer = 0.
  - pix_out = 0, pix_active = 0, done = 0, wr_ready = 1.
- States:
  - FILL: wr_ready = 1. On wr_valid, wr_data is stored into word slot wcnt and wcnt increments. When the WORDS-th word is accepted, go to LOADED.
  - LOADED: wr_ready = 0. On arm, latch x_offset into dcnt and mirror into mir. Go to DELAY if x_offset != 0, else SHIFT.
  - DELAY: each en decrements dcnt. The en that takes dcnt to 0 moves to SHIFT and emits nothing.
  - SHIFT: each en emits one pixel; pix_out <= next pixel, pix_active <= 1, pcnt increments. The en emitting pixel N-1 moves to FILL with wcnt = 0, and done = 1 in the following cycle only.
- Pixel order:
  - Word 0 is leftmost; within a word, pixel 0 (LSBs) is leftmost.
  - mir = 0: emit word0.pix0 … word(WORDS-1).pix(PPW-1).
  - mir = 1: emit the exact reverse order.
- Latency: a pixel appears on pix_out the cycle after its en. pix_out and pix_active hold between en strobes.
- Outside SHIFT, any en sets pix_out <= 0 and pix_active <= 0. So after the last pixel, the next en blanks the output.
- The row buffer is not consumed by shifting; pixels are selected by index. The buffer is overwritten only by new FILL writes.
- arm is ignored in FILL, DELAY and SHIFT. x_offset and mirror are only sampled on an accepted arm.
- wr_valid is ignored while wr_ready = 0; no data is lost or queued.
- Counter widths:
  - wcnt: clog2(WORDS+1).
  - pcnt: clog2(N+1).
  - dcnt: XW; no wrap, saturates at 0.
- en and wr_valid in the same FILL cycle: the write is accepted and en blanks the output. The two actions are independent.
- Next-row writes may begin in FILL while the final pixel is still displayed; pix_out is unaffected until the next en.
- Reset mid-DELAY or mid-SHIFT aborts the row immediately: outputs zero, done not pulsed, previously loaded words discarded.

Test Plan:
- Defaults; write 0x0000_0001 then 0x8000_0000; arm with x_offset=0, mirror=0; 32 en strobes -> pix_out = 1 on the 1st pixel, 0 for pixels 2–31, 2 on the 32nd; done pulses once, 1 cycle after the 32nd en; the 33rd en gives pix_out = 0, pix_active = 0.
- Same data, mirror=1 -> 1st pixel = 2, 32nd pixel = 1, pix_active high for exactly 32 strobes.
- x_offset=5, en every 3rd clock -> first 5 strobes leave pix_active = 0; pixel 0 appears 1 cycle after the 6th strobe; pix_out is stable between strobes.
- Write handshake:
  - wr_valid held high for 4 cycles -> exactly 2 words accepted, wr_ready = 0 after the 2nd.
  - arm asserted during FILL (after 1 word) -> ignored; state stays FILL.
- Assert reset on the 10th SHIFT pixel -> the next cycle shows pix_out = 0, pix_active = 0, wr_ready = 1, done = 0; a fresh 2-word load plus arm replays correctly.
- BPP=4, PPW=8, WORDS=3 -> 24 pixels, with nibble order and mirror verified against a reference model.
